stream_reduce_comp: RTL and testbench

STREAM_REDUCE_COMP -- requirements
Module: stream_reduce_comp

---
 rtl/stream_reduce_pkg.sv | 23 ++
 rtl/reduce_alu.sv | 71 +++++++
 rtl/stream_reduce_comp.sv | 185 ++++++++++++++++++
 tb/tb_stream_reduce_comp.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_reduce_pkg.sv
// rtl/stream_reduce_pkg.sv - mode and FSM encodings shared by the reduce datapath
package stream_reduce_pkg;

    typedef enum logic [1:0] {
        MODE_MAX  = 2'b00,
        MODE_MIN  = 2'b01,
        MODE_SUM  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_DRAIN = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // The reserved encoding behaves as MAX so the latched mode is always one of three.
    function automatic mode_e decode_mode(input logic [1:0] raw);
        return (raw == 2'b11) ? MODE_MAX : mode_e'(raw);
    endfunction

endpackage

// File: rtl/reduce_alu.sv
// rtl/reduce_alu.sv - one reduction step: strict compare for MAX/MIN, saturating add for SUM
module reduce_alu
    import stream_reduce_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int AW     = 3,
    parameter int SIGNED = 0
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [AW-1:0]    idx_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [AW-1:0]    data_idx_i,
    input  mode_e            mode_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [AW-1:0]    idx_o,
    output logic             ovf_o
);

    // Two guard bits keep both unsigned and signed sums exact before clamping.
    localparam int XW = WIDTH + 2;
    localparam logic signed [XW-1:0] MAX_X = (SIGNED != 0) ? XW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1)
                                                          : XW'((64'sd1 <<< WIDTH) - 64'sd1);
    localparam logic signed [XW-1:0] MIN_X = (SIGNED != 0) ? XW'(-(64'sd1 <<< (WIDTH - 1)))
                                                          : XW'(64'sd0);

    logic signed [XW-1:0] acc_x;
    logic signed [XW-1:0] data_x;
    logic signed [XW-1:0] sum_x;

    always_comb begin
        if (SIGNED != 0) begin
            acc_x  = {{2{acc_i[WIDTH-1]}}, acc_i};
            data_x = {{2{data_i[WIDTH-1]}}, data_i};
        end else begin
            acc_x  = {2'b00, acc_i};
            data_x = {2'b00, data_i};
        end
        sum_x = acc_x + data_x;

        acc_o = acc_i;
        idx_o = idx_i;
        ovf_o = 1'b0;
        case (mode_i)
            MODE_SUM: begin
                idx_o = '0;
                if (sum_x > MAX_X) begin
                    acc_o = MAX_X[WIDTH-1:0];
                    ovf_o = 1'b1;
                end else if (sum_x < MIN_X) begin
                    acc_o = MIN_X[WIDTH-1:0];
                    ovf_o = 1'b1;
                end else begin
                    acc_o = sum_x[WIDTH-1:0];
                end
            end
            MODE_MIN: begin
                if (data_x < acc_x) begin
                    acc_o = data_i;
                    idx_o = data_idx_i;
                end
            end
            default: begin
                if (data_x > acc_x) begin
                    acc_o = data_i;
                    idx_o = data_idx_i;
                end
            end
        endcase
    end

endmodule

// File: rtl/stream_reduce_comp.sv
// rtl/stream_reduce_comp.sv - reads N words from memory and reports max, min or saturated sum
module stream_reduce_comp
    import stream_reduce_pkg::*;
#(
    parameter  int SIZE   = 8,
    parameter  int WIDTH  = 10,
    parameter  int SIGNED = 0,
    localparam int AW     = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic [AW:0]      length_in,
    input  logic [1:0]       mode_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] result_out,
    output logic [AW-1:0]    index_out,
    output logic             ovf_out
);

    // Seeds chosen so the first element always wins its compare (or is added to zero).
    localparam logic [WIDTH-1:0] TYPE_MIN = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] TYPE_MAX = (SIGNED != 0) ? {1'b0, {(WIDTH-1){1'b1}}} : {WIDTH{1'b1}};

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [AW:0]      n_q, n_d;
    logic             rd_en_q, rd_en_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic             vld_q, vld_d;
    logic [AW-1:0]    elem_q, elem_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             ovf_run_q, ovf_run_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [AW-1:0]    index_q, index_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] alu_acc;
    logic [AW-1:0]    alu_idx;
    logic             alu_ovf;
    mode_e            start_mode;
    logic [AW:0]      start_n;

    reduce_alu #(
        .WIDTH  (WIDTH),
        .AW     (AW),
        .SIGNED (SIGNED)
    ) u_alu (
        .acc_i      (acc_q),
        .idx_i      (idx_q),
        .data_i     (data_in),
        .data_idx_i (elem_q),
        .mode_i     (mode_q),
        .acc_o      (alu_acc),
        .idx_o      (alu_idx),
        .ovf_o      (alu_ovf)
    );

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        n_d       = n_q;
        rd_en_d   = rd_en_q;
        rd_addr_d = rd_addr_q;
        elem_d    = elem_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        ovf_run_d = ovf_run_q;
        done_d    = 1'b0;
        result_d  = result_q;
        index_d   = index_q;
        ovf_d     = ovf_q;

        start_mode = decode_mode(mode_in);
        start_n    = (length_in > (AW+1)'(SIZE)) ? (AW+1)'(SIZE) : length_in;

        // Read data lands one cycle after the strobe, so consumption trails rd_en by one.
        vld_d = rd_en_q;
        if (vld_q) begin
            acc_d     = alu_acc;
            idx_d     = alu_idx;
            ovf_run_d = ovf_run_q | alu_ovf;
            elem_d    = elem_q + AW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    n_d       = start_n;
                    mode_d    = start_mode;
                    idx_d     = '0;
                    ovf_run_d = 1'b0;
                    elem_d    = '0;
                    result_d  = '0;
                    index_d   = '0;
                    ovf_d     = 1'b0;
                    case (start_mode)
                        MODE_MIN: acc_d = TYPE_MAX;
                        MODE_SUM: acc_d = '0;
                        default:  acc_d = TYPE_MIN;
                    endcase
                    if (start_n == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d   = ST_READ;
                        rd_en_d   = 1'b1;
                        rd_addr_d = '0;
                    end
                end
            end
            ST_READ: begin
                if ({1'b0, rd_addr_q} == n_q - (AW+1)'(1)) begin
                    state_d = ST_DRAIN;
                    rd_en_d = 1'b0;
                end else begin
                    rd_addr_d = rd_addr_q + AW'(1);
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d  = ST_IDLE;
                done_d   = 1'b1;
                result_d = (n_q == '0) ? '0 : acc_q;
                index_d  = idx_q;
                ovf_d    = ovf_run_q;
            end
        endcase

        busy_d = (state_d == ST_READ) || (state_d == ST_DRAIN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_MAX;
            n_q       <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            vld_q     <= 1'b0;
            elem_q    <= '0;
            acc_q     <= '0;
            idx_q     <= '0;
            ovf_run_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            index_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            n_q       <= n_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            vld_q     <= vld_d;
            elem_q    <= elem_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            ovf_run_q <= ovf_run_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            index_q   <= index_d;
            ovf_q     <= ovf_d;
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign busy_out   = busy_q;
    assign done_out   = done_q;
    assign result_out = result_q;
    assign index_out  = index_q;
    assign ovf_out    = ovf_q;

endmodule

// File: tb/tb_stream_reduce_comp.sv
// tb/tb_stream_reduce_comp.sv - directed and random runs on unsigned and signed instances
module tb_stream_reduce_comp;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_in;
    logic [3:0] length_in;
    logic [1:0] mode_in;

    logic [9:0] data_u, data_s, result_u, result_s;
    logic       rd_en_u, rd_en_s, busy_u, busy_s, done_u, done_s, ovf_u, ovf_s;
    logic [2:0] rd_addr_u, rd_addr_s, index_u, index_s;

    logic [9:0] mem [8];
    bit         use_s = 1'b0;
    int         total = 0;
    int         bad   = 0;

    logic       rd_en_m, busy_m, done_m, ovf_m;
    logic [2:0] rd_addr_m, index_m;
    logic [9:0] result_m;

    always #5 clk = ~clk;

    stream_reduce_comp #(.SIZE(8), .WIDTH(10), .SIGNED(0)) dut (
        .clk(clk), .rst(rst), .start_in(start_in), .length_in(length_in), .mode_in(mode_in),
        .data_in(data_u), .rd_en(rd_en_u), .rd_addr(rd_addr_u), .busy_out(busy_u),
        .done_out(done_u), .result_out(result_u), .index_out(index_u), .ovf_out(ovf_u)
    );

    stream_reduce_comp #(.SIZE(8), .WIDTH(10), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .start_in(start_in), .length_in(length_in), .mode_in(mode_in),
        .data_in(data_s), .rd_en(rd_en_s), .rd_addr(rd_addr_s), .busy_out(busy_s),
        .done_out(done_s), .result_out(result_s), .index_out(index_s), .ovf_out(ovf_s)
    );

    always @(posedge clk) begin
        if (rd_en_u) data_u <= mem[rd_addr_u];
        if (rd_en_s) data_s <= mem[rd_addr_s];
    end

    assign rd_en_m   = use_s ? rd_en_s   : rd_en_u;
    assign rd_addr_m = use_s ? rd_addr_s : rd_addr_u;
    assign busy_m    = use_s ? busy_s    : busy_u;
    assign done_m    = use_s ? done_s    : done_u;
    assign result_m  = use_s ? result_s  : result_u;
    assign index_m   = use_s ? index_s   : index_u;
    assign ovf_m     = use_s ? ovf_s     : ovf_u;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int val(input int i, input bit sgn);
        int raw;
        raw = int'(mem[i]);
        return (sgn && raw >= 512) ? raw - 1024 : raw;
    endfunction

    task automatic ref_model(input int n, input int md, input bit sgn,
                             output int res, output int idx, output int ovf);
        int best, v, s, maxv, minv;
        res = 0; idx = 0; ovf = 0;
        maxv = sgn ? 511 : 1023;
        minv = sgn ? -512 : 0;
        if (n == 0) return;
        if (md == 2) begin
            s = 0;
            for (int i = 0; i < n; i++) begin
                s += val(i, sgn);
                if (s > maxv) begin s = maxv; ovf = 1; end
                else if (s < minv) begin s = minv; ovf = 1; end
            end
            res = s & 1023;
        end else begin
            best = val(0, sgn);
            for (int i = 1; i < n; i++) begin
                v = val(i, sgn);
                if ((md == 1) ? (v < best) : (v > best)) begin best = v; idx = i; end
            end
            res = best & 1023;
        end
    endtask

    task automatic run_and_check(input string tag, input int len, input int md,
                                 input int pulse_at, input bit keep, input bit launched);
        int n, lat, rds, er, ei, eo;
        bit addr_ok, busy_ok;
        n = (len > 8) ? 8 : len;
        ref_model(n, md, use_s, er, ei, eo);
        if (!launched) @(negedge clk);
        start_in  = 1'b1;
        length_in = len[3:0];
        mode_in   = md[1:0];
        @(posedge clk);
        lat = -1; rds = 0; addr_ok = 1'b1; busy_ok = 1'b1;
        for (int k = 0; k < 64 && lat < 0; k++) begin
            @(negedge clk);
            if (!keep) start_in = (k == pulse_at);
            if (rd_en_m) begin
                if (int'(rd_addr_m) != rds) addr_ok = 1'b0;
                rds++;
            end
            if (busy_m !== (n > 0 && k <= n)) busy_ok = 1'b0;
            if (done_m) lat = k;
        end
        chk({tag, " latency"}, lat, (n == 0) ? 1 : n + 2);
        chk({tag, " rd_en cycles"}, rds, n);
        chk({tag, " rd_addr seq"}, addr_ok, 1);
        chk({tag, " busy"}, busy_ok, 1);
        chk({tag, " result"}, result_m, er);
        chk({tag, " index"}, index_m, ei);
        chk({tag, " ovf"}, ovf_m, eo);
        if (!keep) begin
            @(negedge clk);
            chk({tag, " done one-cycle"}, done_m, 0);
        end
    endtask

    initial begin
        int seen;
        rst = 1'b0; start_in = 1'b1; length_in = 4'd5; mode_in = 2'd0;
        mem = '{10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
        repeat (3) @(negedge clk);
        chk("reset rd_en", rd_en_u, 0);
        chk("reset rd_addr", rd_addr_u, 0);
        chk("reset busy", busy_u, 0);
        chk("reset done", done_u, 0);
        chk("reset result", result_u, 0);
        chk("reset index", index_u, 0);
        chk("reset ovf", ovf_u, 0);
        start_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        mem = '{10'd3, 10'd9, 10'd2, 10'd9, 10'd5, 10'd0, 10'd0, 10'd0};
        run_and_check("max", 5, 0, -1, 1'b0, 1'b0);
        chk("max literal result", result_u, 9);
        chk("max literal index", index_u, 1);

        mem = '{10'd7, 10'd4, 10'd8, 10'd4, 10'd1, 10'd6, 10'd0, 10'd0};
        run_and_check("min", 6, 1, -1, 1'b1, 1'b0);
        chk("min literal result", result_u, 1);
        chk("min literal index", index_u, 4);
        mem = '{10'd1, 10'd2, 10'd3, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
        run_and_check("b2b sum", 3, 2, -1, 1'b0, 1'b1);
        chk("b2b sum literal", result_u, 6);

        mem = '{10'd1000, 10'd20, 10'd5, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
        run_and_check("sum sat", 3, 2, -1, 1'b0, 1'b0);
        chk("sum sat literal", result_u, 1023);
        chk("sum sat ovf literal", ovf_u, 1);

        use_s = 1'b1;
        mem = '{10'h3FD, 10'h3FF, 10'h3F9, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0};
        run_and_check("signed max", 3, 0, -1, 1'b0, 1'b0);
        chk("signed max literal", result_s, 10'h3FF);
        chk("signed max idx literal", index_s, 1);
        use_s = 1'b0;

        run_and_check("n0", 0, 1, -1, 1'b0, 1'b0);
        chk("n0 literal result", result_u, 0);

        for (int i = 0; i < 8; i++) mem[i] = 10'($urandom_range(0, 1023));
        run_and_check("clamp12", 12, 0, 3, 1'b0, 1'b0);

        @(negedge clk);
        start_in = 1'b1; length_in = 4'd5; mode_in = 2'd2;
        @(posedge clk);
        @(negedge clk); start_in = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("midrst rd_en", rd_en_u, 0);
        chk("midrst rd_addr", rd_addr_u, 0);
        chk("midrst busy", busy_u, 0);
        chk("midrst done", done_u, 0);
        chk("midrst result", result_u, 0);
        rst = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done_u) seen++;
        end
        chk("midrst no done", seen, 0);

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 8; i++) mem[i] = 10'($urandom_range(0, 1023));
            use_s = 1'($urandom_range(0, 1));
            run_and_check("rand", $urandom_range(0, 12), $urandom_range(0, 3), -1, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
